// File: rtl/pio_display_pkg.sv
// rtl/pio_display_pkg.sv - shared types, segment constants and BCD decode for the PIO display block
package pio_display_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7F;

  // Active-high segments ordered {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pio_display_ctrl_pwm_phase_gen.sv
// rtl/pio_display_ctrl_pwm_phase_gen.sv - prescaler and 8-bit PWM phase with period boundary flag
module pwm_phase_gen #(
  parameter int PRESCALE = 195
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] phase,
  output logic       tick,
  output logic       boundary
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick     = (count == LAST);
  assign boundary = tick && (phase == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= 8'h00;
    end else if (tick) begin
      count <= '0;
      phase <= phase + 8'd1;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pio_display_ctrl.sv
// rtl/pio_display_ctrl.sv - double-buffered 3-digit 7-segment driver with PWM brightness and LED mirror
module pio_display_ctrl
  import pio_display_pkg::*;
#(
  parameter int PRESCALE    = 195,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        lamp_test,
  input  logic [11:0] bcd_in,
  input  logic [7:0]  duty_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic        led_pwm,
  output logic        bcd_err,
  output logic        period_strobe
);

  localparam logic [6:0] POL = SEG_ACT_LOW ? 7'h7F : 7'h00;

  state_t      state, state_nx;
  logic [11:0] bcd_sh;
  logic [7:0]  duty_sh;
  logic [7:0]  phase;
  logic        tick, boundary, period_end, load, pwm_on;
  logic [3:0]  d2, d1, d0;
  logic        blank2, blank1;
  logic [6:0]  seg2, seg1, seg0;
  logic [6:0]  hex2_d, hex1_d, hex0_d;
  logic        led_d;

  pwm_phase_gen #(.PRESCALE(PRESCALE)) u_phase (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .phase    (phase),
    .tick     (tick),
    .boundary (boundary)
  );

  assign period_end = tick && boundary;
  // A disable that coincides with the boundary must not load the shadows.
  assign load       = period_end && enable;
  assign pwm_on     = (duty_sh == 8'hFF) || (phase < duty_sh);

  assign d2     = bcd_sh[11:8];
  assign d1     = bcd_sh[7:4];
  assign d0     = bcd_sh[3:0];
  assign blank2 = BLANK_LZ && (d2 == 4'd0);
  assign blank1 = blank2 && (d1 == 4'd0);
  assign seg2   = blank2 ? SEG_BLANK : bcd_to_seg(d2);
  assign seg1   = blank1 ? SEG_BLANK : bcd_to_seg(d1);
  assign seg0   = bcd_to_seg(d0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = ARM;
      ARM:     if (period_end) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end

  // Enable is gated here as well so the pins go dark one clock after it drops.
  always_comb begin
    hex2_d = SEG_BLANK;
    hex1_d = SEG_BLANK;
    hex0_d = SEG_BLANK;
    led_d  = 1'b0;
    if (lamp_test) begin
      hex2_d = SEG_ALL;
      hex1_d = SEG_ALL;
      hex0_d = SEG_ALL;
      led_d  = 1'b1;
    end else if (enable && (state == RUN) && pwm_on) begin
      hex2_d = seg2;
      hex1_d = seg1;
      hex0_d = seg0;
      led_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      bcd_sh        <= 12'h000;
      duty_sh       <= 8'h00;
      bcd_err       <= 1'b0;
      period_strobe <= 1'b0;
      hex2          <= POL;
      hex1          <= POL;
      hex0          <= POL;
      led_pwm       <= 1'b0;
    end else begin
      state         <= state_nx;
      period_strobe <= period_end;
      if (load) begin
        bcd_sh  <= bcd_in;
        duty_sh <= duty_in;
        bcd_err <= (bcd_in[11:8] > 4'd9) || (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
      end
      hex2    <= hex2_d ^ POL;
      hex1    <= hex1_d ^ POL;
      hex0    <= hex0_d ^ POL;
      led_pwm <= led_d;
    end
  end

endmodule

// File: tb/tb_pio_display_ctrl.sv
// tb/tb_pio_display_ctrl.sv - scoreboard bench for pio_display_ctrl at PRESCALE 2
module tb_pio_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        lamp_test = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic [7:0]  duty_in = 8'h00;
  logic [6:0]  hex0, hex1, hex2;
  logic        led_pwm, bcd_err, period_strobe;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [6:0] h2, h1, h0;
    logic       led, err;
  } exp_t;

  exp_t exp_q[$];

  pio_display_ctrl #(.PRESCALE(2), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b1)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .lamp_test     (lamp_test),
    .bcd_in        (bcd_in),
    .duty_in       (duty_in),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .led_pwm       (led_pwm),
    .bcd_err       (bcd_err),
    .period_strobe (period_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Pins one clock after each strobe reflect the newly loaded shadows at phase 0.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && period_strobe) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_hex2", hex2, e.h2);
          chk("sb_hex1", hex1, e.h1);
          chk("sb_hex0", hex0, e.h0);
          chk("sb_led", led_pwm, e.led);
          chk("sb_bcd_err", bcd_err, e.err);
          chk("sb_strobe_width", period_strobe, 1'b0);
        end
      end
    end
  end

  // Apply inputs, queue what the next boundary must show, then run out the current period.
  task automatic period(input logic [11:0] bcd, input logic [7:0] duty,
                        input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0,
                        input logic eled, input logic eerr, input int exp_hi, input bit arm_chk);
    int   n = 0;
    int   hi = 0;
    int   lit = 0;
    exp_t e;
    bcd_in  = bcd;
    duty_in = duty;
    e.h2 = e2; e.h1 = e1; e.h0 = e0; e.led = eled; e.err = eerr;
    exp_q.push_back(e);
    do begin
      @(negedge clk);
      n++;
      if (led_pwm) hi++;
      if ({hex2, hex1, hex0} != {3{7'h7F}}) lit++;
    end while (!period_strobe && n < 600);
    chk("period_len", n, 512);
    chk("led_on_cycles", hi, exp_hi);
    if (arm_chk) chk("arm_dark", lit, 0);
  endtask

  initial begin : stim
    int n;
    bcd_in  = 12'h123;
    duty_in = 8'd128;
    #12;
    chk("rst_hex2", hex2, 7'h7F);
    chk("rst_hex0", hex0, 7'h7F);
    chk("rst_led", led_pwm, 1'b0);
    chk("rst_err", bcd_err, 1'b0);
    chk("rst_strobe", period_strobe, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    period(12'h123, 8'd128, 7'h79, 7'h24, 7'h30, 1'b1, 1'b0, 0,   1'b1);
    period(12'h007, 8'd128, 7'h7F, 7'h7F, 7'h78, 1'b1, 1'b0, 256, 1'b0);
    period(12'h070, 8'd128, 7'h7F, 7'h78, 7'h40, 1'b1, 1'b0, 256, 1'b0);
    period(12'h1A3, 8'd128, 7'h79, 7'h3F, 7'h30, 1'b1, 1'b1, 256, 1'b0);
    period(12'h123, 8'd128, 7'h79, 7'h24, 7'h30, 1'b1, 1'b0, 256, 1'b0);
    period(12'h0A0, 8'd0,   7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b1, 256, 1'b0);
    period(12'h900, 8'd0,   7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b0, 0,   1'b0);
    period(12'h900, 8'd0,   7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b0, 0,   1'b0);
    period(12'h900, 8'd255, 7'h10, 7'h40, 7'h40, 1'b1, 1'b0, 0,   1'b0);
    period(12'h123, 8'd128, 7'h79, 7'h24, 7'h30, 1'b1, 1'b0, 512, 1'b0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    chk("run_led", led_pwm, 1'b1);

    enable = 1'b0;
    @(negedge clk);
    chk("dis_hex2", hex2, 7'h7F);
    chk("dis_hex0", hex0, 7'h7F);
    chk("dis_led", led_pwm, 1'b0);
    lamp_test = 1'b1;
    @(negedge clk);
    chk("lamp_hex", {hex2, hex1, hex0}, 21'h0);
    chk("lamp_led", led_pwm, 1'b1);
    lamp_test = 1'b0;
    @(negedge clk);
    chk("unlamp_hex", {hex2, hex1, hex0}, {3{7'h7F}});
    chk("unlamp_led", led_pwm, 1'b0);

    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strobe && n < 600);
    chk("rearm_strobe_seen", period_strobe, 1'b1);
    repeat (2) @(negedge clk);
    chk("rerun_led", led_pwm, 1'b1);
    chk("rerun_hex0", hex0, 7'h30);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hex", {hex2, hex1, hex0}, {3{7'h7F}});
    chk("async_led", led_pwm, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    period(12'h123, 8'd128, 7'h79, 7'h24, 7'h30, 1'b1, 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
